// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared definitions for the RV32 pipeline hazard controller:
// FSM state encodings, the load result-select code, the wait-counter width
// and a helper that detects a load-use dependency.
package pipe_ctl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2,
        REDIRECT = 2'd3
    } ctl_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam int         WAIT_CNT_W      = 8;

    // A load in execute whose destination feeds either decode source operand.
    // x0 is never a real dependency.
    function automatic logic load_use_hit(
        input logic [1:0] result_src_e,
        input logic [4:0] rd_e,
        input logic [4:0] rs1_d,
        input logic [4:0] rs2_d
    );
        return (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave). Inputs to the controller keep the i_ prefix,
// controller outputs keep the o_ prefix, matching the core's port names.
interface pipe_hazard_ctl_if;
    logic [4:0]  i_rs1_d;
    logic [4:0]  i_rs2_d;
    logic [4:0]  i_rd_e;
    logic [1:0]  i_result_src_e;
    logic        i_pc_src_e;
    logic        i_dmem_req_m;
    logic        i_dmem_ready_m;
    logic        i_exception_m;
    logic        o_stall_f;
    logic        o_stall_d;
    logic        o_flush_d;
    logic        o_clk_en_e;
    logic        o_flush_e;
    logic        o_flush_exc_m;
    logic        o_trap_redirect;
    logic        o_mem_timeout;
    logic [1:0]  o_state;
    logic [31:0] o_stall_cycles;
    logic [31:0] o_flush_events;

    modport master (
        output i_rs1_d, i_rs2_d, i_rd_e, i_result_src_e, i_pc_src_e,
               i_dmem_req_m, i_dmem_ready_m, i_exception_m,
        input  o_stall_f, o_stall_d, o_flush_d, o_clk_en_e, o_flush_e,
               o_flush_exc_m, o_trap_redirect, o_mem_timeout, o_state,
               o_stall_cycles, o_flush_events
    );

    modport slave (
        input  i_rs1_d, i_rs2_d, i_rd_e, i_result_src_e, i_pc_src_e,
               i_dmem_req_m, i_dmem_ready_m, i_exception_m,
        output o_stall_f, o_stall_d, o_flush_d, o_clk_en_e, o_flush_e,
               o_flush_exc_m, o_trap_redirect, o_mem_timeout, o_state,
               o_stall_cycles, o_flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctl_perf.sv
// Performance counters for the hazard controller: stalled decode cycles and
// flush events, both wrapping modulo 2^32. The module only exists when
// PIPE_HAZARD_CTL_PERF_EN is defined, so no counter flops are built otherwise.
`ifdef PIPE_HAZARD_CTL_PERF_EN
module pipe_ctl_perf (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_events
);
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Count every stalled-decode cycle and every flush cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (i_stall) stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (i_flush) flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cnt_reg;
    assign o_flush_events = flush_cnt_reg;
endmodule
`endif

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller for the five-stage RV32 core. Decides each cycle
// whether IF/ID, ID/EX and EX/MEM advance, hold or clear: load-use bubbles,
// branch/jump flushes, data-memory waits with timeout, and a two-cycle trap
// sequence (TRAP then REDIRECT). Optional perf counters: PIPE_HAZARD_CTL_PERF_EN.
module pipe_hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pipe_hazard_ctl_if.slave  bus
);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    ctl_state_t            state_reg, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic stall_f_c, stall_d_c, flush_d_c, clk_en_e_c, flush_e_c;
    logic flush_exc_m_c, trap_redirect_c, mem_timeout_c;
    logic stall_f, stall_d, flush_e, flush_exc_m;

    // State and memory-wait counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state and control decode; priority inside RUN is
    // exception > memory wait > branch > load-use.
    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        stall_f_c       = 1'b0;
        stall_d_c       = 1'b0;
        flush_d_c       = 1'b0;
        clk_en_e_c      = 1'b1;
        flush_e_c       = 1'b0;
        flush_exc_m_c   = 1'b0;
        trap_redirect_c = 1'b0;
        mem_timeout_c   = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (bus.i_exception_m) begin
                    flush_d_c     = 1'b1;
                    flush_e_c     = 1'b1;
                    flush_exc_m_c = 1'b1;
                    stall_f_c     = 1'b1;
                    state_next    = TRAP;
                end else if (bus.i_dmem_req_m && !bus.i_dmem_ready_m) begin
                    stall_f_c     = 1'b1;
                    stall_d_c     = 1'b1;
                    clk_en_e_c    = 1'b0;
                    wait_cnt_next = WAIT_CNT_W'(1);
                    state_next    = MEM_WAIT;
                end else if (bus.i_pc_src_e) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (load_use_hit(bus.i_result_src_e, bus.i_rd_e,
                                          bus.i_rs1_d, bus.i_rs2_d)) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Memory stage is frozen here, so exceptions are not sampled.
                if (bus.i_dmem_ready_m) begin
                    state_next = RUN;
                end else if (wait_cnt_reg >= TIMEOUT_VAL) begin
                    mem_timeout_c = 1'b1;
                    flush_d_c     = 1'b1;
                    flush_e_c     = 1'b1;
                    flush_exc_m_c = 1'b1;
                    stall_f_c     = 1'b1;
                    state_next    = TRAP;
                end else begin
                    stall_f_c     = 1'b1;
                    stall_d_c     = 1'b1;
                    clk_en_e_c    = 1'b0;
                    wait_cnt_next = wait_cnt_reg + WAIT_CNT_W'(1);
                end
            end
            TRAP: begin
                flush_d_c     = 1'b1;
                flush_e_c     = 1'b1;
                flush_exc_m_c = 1'b1;
                stall_f_c     = 1'b1;
                state_next    = REDIRECT;
            end
            REDIRECT: begin
                trap_redirect_c = 1'b1;
                flush_d_c       = 1'b1;
                state_next      = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Reset overrides every control output with its idle value.
    assign stall_f     = stall_f_c     & ~i_rst;
    assign stall_d     = stall_d_c     & ~i_rst;
    assign flush_e     = flush_e_c     & ~i_rst;
    assign flush_exc_m = flush_exc_m_c & ~i_rst;

    assign bus.o_stall_f       = stall_f;
    assign bus.o_stall_d       = stall_d;
    assign bus.o_flush_d       = flush_d_c       & ~i_rst;
    assign bus.o_clk_en_e      = clk_en_e_c      |  i_rst;
    assign bus.o_flush_e       = flush_e;
    assign bus.o_flush_exc_m   = flush_exc_m;
    assign bus.o_trap_redirect = trap_redirect_c & ~i_rst;
    assign bus.o_mem_timeout   = mem_timeout_c   & ~i_rst;
    assign bus.o_state         = state_reg;

`ifdef PIPE_HAZARD_CTL_PERF_EN
    pipe_ctl_perf u_perf (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_stall        (stall_d),
        .i_flush        (flush_e | flush_exc_m),
        .o_stall_cycles (bus.o_stall_cycles),
        .o_flush_events (bus.o_flush_events)
    );
`else
    assign bus.o_stall_cycles = 32'd0;
    assign bus.o_flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: the driver applies one directed
// vector per cycle and queues its hand-computed expected controls; the
// monitor pops one entry per cycle on the falling edge and compares.
module tb_pipe_hazard_ctl;
    import pipe_ctl_pkg::*;

    // Expected control bundle bit order:
    // {stall_f, stall_d, flush_d, clk_en_e, flush_e, flush_exc_m, trap_redirect, mem_timeout}
    localparam logic [7:0] C_IDLE = 8'b0001_0000;
    localparam logic [7:0] C_LU   = 8'b1101_1000;
    localparam logic [7:0] C_BR   = 8'b0011_1000;
    localparam logic [7:0] C_MW   = 8'b1100_0000;
    localparam logic [7:0] C_EXC  = 8'b1011_1100;
    localparam logic [7:0] C_TO   = 8'b1011_1101;
    localparam logic [7:0] C_RD   = 8'b0011_0010;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic [1:0]  st;
        bit          chk_perf;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    pipe_hazard_ctl_if bus ();

    pipe_hazard_ctl #(.MEM_TIMEOUT(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string name, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [1:0] rsrc, input logic pc, input logic req,
                        input logic rdy, input logic exc,
                        input logic [7:0] ctl, input logic [1:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = r;
        bus.i_rs1_d        = rs1;
        bus.i_rs2_d        = rs2;
        bus.i_rd_e         = rd;
        bus.i_result_src_e = rsrc;
        bus.i_pc_src_e     = pc;
        bus.i_dmem_req_m   = req;
        bus.i_dmem_ready_m = rdy;
        bus.i_exception_m  = exc;
        e.name      = name;
        e.ctl       = ctl;
        e.st        = st;
        e.chk_perf  = 1'b0;
        e.stall_cnt = '0;
        e.flush_cnt = '0;
        sb_q.push_back(e);
    endtask

    // Attach a perf-counter expectation to the vector just queued.
    task automatic perf_expect(input logic [31:0] sc, input logic [31:0] fe);
`ifdef PIPE_HAZARD_CTL_PERF_EN
        sb_q[sb_q.size()-1].stall_cnt = sc;
        sb_q[sb_q.size()-1].flush_cnt = fe;
`else
        sb_q[sb_q.size()-1].stall_cnt = 32'd0 & sc;
        sb_q[sb_q.size()-1].flush_cnt = 32'd0 & fe;
`endif
        sb_q[sb_q.size()-1].chk_perf = 1'b1;
    endtask

    // Monitor: one expected entry per cycle, checked mid-cycle.
    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = {bus.o_stall_f, bus.o_stall_d, bus.o_flush_d, bus.o_clk_en_e,
                       bus.o_flush_e, bus.o_flush_exc_m, bus.o_trap_redirect, bus.o_mem_timeout};
                n_checks++;
                if (got !== e.ctl || bus.o_state !== e.st) begin
                    n_fail++;
                    $display("FAIL %s: ctl=%b state=%0d, expected ctl=%b state=%0d",
                             e.name, got, bus.o_state, e.ctl, e.st);
                end else begin
                    $display("ok   %s: ctl=%b state=%0d", e.name, got, bus.o_state);
                end
                if (e.chk_perf) begin
                    n_checks++;
                    if (bus.o_stall_cycles !== e.stall_cnt || bus.o_flush_events !== e.flush_cnt) begin
                        n_fail++;
                        $display("FAIL %s perf: stall_cycles=%0d flush_events=%0d, expected %0d %0d",
                                 e.name, bus.o_stall_cycles, bus.o_flush_events,
                                 e.stall_cnt, e.flush_cnt);
                    end else begin
                        $display("ok   %s perf: stall_cycles=%0d flush_events=%0d",
                                 e.name, bus.o_stall_cycles, bus.o_flush_events);
                    end
                end
            end
        end
    end

    // Driver: directed vectors with hand-computed expectations.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_rs1_d = '0; bus.i_rs2_d = '0; bus.i_rd_e = '0; bus.i_result_src_e = '0;
        bus.i_pc_src_e = 1'b0; bus.i_dmem_req_m = 1'b0; bus.i_dmem_ready_m = 1'b0;
        bus.i_exception_m = 1'b0;

        //    name           rst rs1 rs2 rd rsrc  pc req rdy exc  ctl     state
        step("rst_exc",      1,  0,  0,  0, 2'b00, 1, 1,  0,  1,  C_IDLE, RUN);
        perf_expect(0, 0);
        step("rst_lu",       1,  5,  0,  5, 2'b01, 0, 0,  0,  0,  C_IDLE, RUN);
        step("idle",         0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        step("lu_rs1",       0,  5,  0,  5, 2'b01, 0, 0,  0,  0,  C_LU,   RUN);
        step("lu_rd0",       0,  0,  0,  0, 2'b01, 0, 0,  0,  0,  C_IDLE, RUN);
        step("lu_rs2",       0,  1,  7,  7, 2'b01, 0, 0,  0,  0,  C_LU,   RUN);
        step("no_load",      0,  7,  7,  7, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        step("br_plus_lu",   0,  5,  0,  5, 2'b01, 1, 0,  0,  0,  C_BR,   RUN);
        step("mem_ready0",   0,  0,  0,  0, 2'b00, 0, 1,  1,  0,  C_IDLE, RUN);
        // three cycles of ready low, ready in the fourth
        step("mw_req",       0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   RUN);
        step("mw_wait1",     0,  0,  0,  0, 2'b00, 0, 1,  0,  1,  C_MW,   MEM_WAIT);
        step("mw_wait2",     0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   MEM_WAIT);
        step("mw_release",   0,  0,  0,  0, 2'b00, 0, 1,  1,  0,  C_IDLE, MEM_WAIT);
        step("mw_back_run",  0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        // bus timeout after four stalled cycles
        step("to_req",       0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   RUN);
        step("to_w1",        0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   MEM_WAIT);
        step("to_w2",        0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   MEM_WAIT);
        step("to_w3",        0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   MEM_WAIT);
        step("to_pulse",     0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_TO,   MEM_WAIT);
        step("to_trap",      0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_EXC,  TRAP);
        step("to_redirect",  0,  0,  0,  0, 2'b00, 1, 1,  0,  1,  C_RD,   REDIRECT);
        step("to_run",       0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        // exception beats branch and memory wait
        step("exc_compete",  0,  5,  0,  5, 2'b01, 1, 1,  0,  1,  C_EXC,  RUN);
        step("exc_trap",     0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_EXC,  TRAP);
        step("exc_redirect", 0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_RD,   REDIRECT);
        step("exc_run",      0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        // reset while in MEM_WAIT
        step("rw_req",       0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   RUN);
        step("rw_wait",      0,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_MW,   MEM_WAIT);
        step("rw_reset",     1,  0,  0,  0, 2'b00, 0, 1,  0,  0,  C_IDLE, RUN);
        step("rw_after",     0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        // perf: two load-use bubbles and one branch from a fresh reset
        step("pf_reset",     1,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        perf_expect(0, 0);
        step("pf_lu1",       0,  3,  0,  3, 2'b01, 0, 0,  0,  0,  C_LU,   RUN);
        step("pf_idle1",     0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        step("pf_lu2",       0,  0,  9,  9, 2'b01, 0, 0,  0,  0,  C_LU,   RUN);
        step("pf_br",        0,  0,  0,  0, 2'b00, 1, 0,  0,  0,  C_BR,   RUN);
        step("pf_idle2",     0,  0,  0,  0, 2'b00, 0, 0,  0,  0,  C_IDLE, RUN);
        perf_expect(2, 3);

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
